fact_sequencer: RTL

Bus-master sequencer sitting directly upstream of the factorial accelerator's memory-mapped port (we / a[1:0] / d[3:0] in, 32-bit read data out). It accepts a factorial request over a valid/ready handshake and drives the accelerator's register interface: write N, pulse GO, clear GO, poll STATUS, read RESULT. It returns the result over a valid/ready response channel. It offloads the processor from polling and adds timeout and overflow reporting.

---
 rtl/fseq_pkg.sv | 64 ++++++
 rtl/fseq_timer.sv | 30 +++
 rtl/fact_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fseq_pkg.sv
// Shared types and constants for the factorial bus-master sequencer.
package fseq_pkg;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned NDATA_W   = 4;
    localparam int unsigned RDATA_W   = 32;
    localparam int unsigned OVF_LIMIT = 12;

    localparam logic [ADDR_W-1:0] ADDR_N      = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_GO     = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_RESULT = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_N   = 3'd1,
        WR_GO  = 3'd2,
        CLR_GO = 3'd3,
        POLL   = 3'd4,
        READ   = 3'd5,
        RESP   = 3'd6
    } state_t;

    // Response channel payload
    typedef struct packed {
        logic [RDATA_W-1:0] data;
        logic               ovf;
        logic               err;
    } resp_t;

    // Accelerator register-port command
    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  a;
        logic [NDATA_W-1:0] d;
    } bus_t;

    // Bus command implied by a state; the sequencer is Moore on the bus side
    function automatic bus_t bus_decode(input state_t s, input logic [NDATA_W-1:0] n);
        bus_t b;
        b = '0;
        case (s)
            WR_N: begin
                b.we = 1'b1;
                b.a  = ADDR_N;
                b.d  = n;
            end
            WR_GO: begin
                b.we = 1'b1;
                b.a  = ADDR_GO;
                b.d  = NDATA_W'(1);
            end
            CLR_GO: begin
                b.we = 1'b1;
                b.a  = ADDR_GO;
            end
            POLL:    b.a = ADDR_STATUS;
            READ:    b.a = ADDR_RESULT;
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fseq_timer.sv
// Poll-cycle counter for the sequencer's status timeout.
module fseq_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic Clk,
    input  logic Rst,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Cleared when polling begins, advanced on every poll that sees no status
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // High on the last permitted poll cycle
    assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fact_sequencer.sv
// Factorial request sequencer: drives the accelerator register port
// (write N, pulse GO, clear GO, poll STATUS, read RESULT) and returns
// the result with overflow/timeout flags.
// Build option: FSEQ_TIMEOUT_EN enables the poll timeout counter; without
// it POLL waits indefinitely and resp_err stays 0.
module fact_sequencer
    import fseq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                req_valid,
    input  logic [NDATA_W-1:0]  req_n,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [RDATA_W-1:0]  resp_data,
    output logic                resp_ovf,
    output logic                resp_err,
    input  logic                resp_ready,
    output logic                acc_we,
    output logic [ADDR_W-1:0]   acc_a,
    output logic [NDATA_W-1:0]  acc_d,
    input  logic [RDATA_W-1:0]  acc_rd
);

    if ((TIMEOUT == 0) || (TIMEOUT > 65535)) begin : g_timeout_range
        $error("fact_sequencer: TIMEOUT must lie in 1..65535");
    end

    state_t               state_q, state_d;
    logic [NDATA_W-1:0]   n_q, n_d;
    resp_t                pay_q, pay_d;
    bus_t                 bus_q, bus_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;

`ifdef FSEQ_TIMEOUT_EN
    logic tmr_load;
    logic tmr_en;
    logic tmr_expired_c;

    fseq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (tmr_load),
        .en        (tmr_en),
        .expired_c (tmr_expired_c)
    );
`endif

    // State, operand, response payload and registered port outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            pay_q        <= '0;
            bus_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            pay_q        <= pay_d;
            bus_q        <= bus_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Next state, payload updates, and outputs decoded from the next state
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        pay_d   = pay_q;
`ifdef FSEQ_TIMEOUT_EN
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    n_d       = req_n;
                    pay_d.ovf = (req_n > NDATA_W'(OVF_LIMIT));
                    state_d   = WR_N;
                end
            end
            WR_N:  state_d = WR_GO;
            WR_GO: state_d = CLR_GO;
            CLR_GO: begin
`ifdef FSEQ_TIMEOUT_EN
                tmr_load = 1'b1;
`endif
                state_d = POLL;
            end
            POLL: begin
                // Status wins over an expiring timer on the same cycle
                if (acc_rd[0]) begin
                    state_d = READ;
                end
`ifdef FSEQ_TIMEOUT_EN
                else if (tmr_expired_c) begin
                    pay_d.err  = 1'b1;
                    pay_d.data = '0;
                    state_d    = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
`endif
            end
            READ: begin
                pay_d.data = acc_rd;
                pay_d.err  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        bus_d        = bus_decode(state_d, n_d);
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = pay_q.data;
    assign resp_ovf   = pay_q.ovf;
    assign resp_err   = pay_q.err;
    assign acc_we     = bus_q.we;
    assign acc_a      = bus_q.a;
    assign acc_d      = bus_q.d;

endmodule
